panel_frame_sched: RTL and testbench

PANEL_FRAME_SCHED -- requirements
Module: panel_frame_sched

---
 rtl/panel_frame_sched.sv | 164 ++++++++++++++++
 tb/tb_panel_frame_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/panel_frame_sched.sv
// Frame scheduler for a chained LED panel driver: sequences driver reset/enable,
// applies double-buffer swaps and staged configuration at frame boundaries, and guards frames with a watchdog.
module panel_frame_sched #(
  parameter int unsigned N_ROWS_MAX    = 64,
  parameter int unsigned N_COLS_MAX    = 256,
  parameter int unsigned BITDEPTH_MAX  = 8,
  parameter int unsigned LSB_BLANK_MAX = 200,
  parameter int unsigned CTRL_WIDTH    = 32,
  parameter int unsigned RECONF_CYCLES = 2,
  parameter int unsigned WDOG_CYCLES   = 1000000
) (
  input  logic                  clk,
  input  logic                  ctrl_rst_n,
  input  logic                  ctrl_en,
  input  logic [CTRL_WIDTH-1:0] cfg_n_rows,
  input  logic [CTRL_WIDTH-1:0] cfg_n_cols,
  input  logic [CTRL_WIDTH-1:0] cfg_bitdepth,
  input  logic [CTRL_WIDTH-1:0] cfg_lsb_blank,
  input  logic                  cfg_commit,
  input  logic                  swap_req,
  input  logic                  frame_done,
  output logic [CTRL_WIDTH-1:0] act_n_rows,
  output logic [CTRL_WIDTH-1:0] act_n_cols,
  output logic [CTRL_WIDTH-1:0] act_bitdepth,
  output logic [CTRL_WIDTH-1:0] act_lsb_blank,
  output logic                  drv_en,
  output logic                  drv_rst,
  output logic                  disp_buffer,
  output logic                  wr_buffer,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  cfg_err,
  output logic                  wdog_err,
  output logic [15:0]           frame_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECONF = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  localparam int unsigned RC_W = (RECONF_CYCLES > 1) ? $clog2(RECONF_CYCLES) : 1;
  localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECONF_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  localparam logic [CTRL_WIDTH-1:0] ROWS_LIM  = CTRL_WIDTH'(N_ROWS_MAX);
  localparam logic [CTRL_WIDTH-1:0] COLS_LIM  = CTRL_WIDTH'(N_COLS_MAX);
  localparam logic [CTRL_WIDTH-1:0] DEPTH_LIM = CTRL_WIDTH'(BITDEPTH_MAX);
  localparam logic [CTRL_WIDTH-1:0] BLANK_LIM = CTRL_WIDTH'(LSB_BLANK_MAX);

  function automatic logic cfg_ok(input logic [CTRL_WIDTH-1:0] rows,
                                  input logic [CTRL_WIDTH-1:0] cols,
                                  input logic [CTRL_WIDTH-1:0] depth,
                                  input logic [CTRL_WIDTH-1:0] blank);
    return (rows  != '0) && (rows  <= ROWS_LIM) &&
           (cols  != '0) && (cols  <= COLS_LIM) &&
           (depth != '0) && (depth <= DEPTH_LIM) &&
           (blank <= BLANK_LIM);
  endfunction

  logic [1:0]            state;
  logic [RC_W-1:0]       rc_cnt;
  logic [WD_W-1:0]       wdog_cnt;
  logic                  commit_pending;
  logic                  commit_valid;
  logic [CTRL_WIDTH-1:0] stg_n_rows;
  logic [CTRL_WIDTH-1:0] stg_n_cols;
  logic [CTRL_WIDTH-1:0] stg_bitdepth;
  logic [CTRL_WIDTH-1:0] stg_lsb_blank;

  assign commit_valid = cfg_commit && cfg_ok(cfg_n_rows, cfg_n_cols, cfg_bitdepth, cfg_lsb_blank);
  assign drv_en       = (state == S_RUN);
  assign drv_rst      = (state == S_RECONF);
  assign wr_buffer    = ~disp_buffer;

  // Staged config is only observed while commit_pending is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (commit_valid) begin
      stg_n_rows    <= cfg_n_rows;
      stg_n_cols    <= cfg_n_cols;
      stg_bitdepth  <= cfg_bitdepth;
      stg_lsb_blank <= cfg_lsb_blank;
    end
  end

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state          <= S_IDLE;
      rc_cnt         <= '0;
      wdog_cnt       <= '0;
      commit_pending <= 1'b0;
      swap_pending   <= 1'b0;
      swap_done      <= 1'b0;
      disp_buffer    <= 1'b0;
      frame_cnt      <= '0;
      cfg_err        <= 1'b0;
      wdog_err       <= 1'b0;
      act_n_rows     <= ROWS_LIM;
      act_n_cols     <= COLS_LIM;
      act_bitdepth   <= DEPTH_LIM;
      act_lsb_blank  <= '0;
    end else begin
      swap_done <= 1'b0;
      if (cfg_commit && !commit_valid) cfg_err <= 1'b1;

      if (!ctrl_en) begin
        state    <= S_IDLE;
        wdog_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_RECONF;
            rc_cnt <= '0;
            if (commit_pending) begin
              act_n_rows     <= stg_n_rows;
              act_n_cols     <= stg_n_cols;
              act_bitdepth   <= stg_bitdepth;
              act_lsb_blank  <= stg_lsb_blank;
              commit_pending <= 1'b0;
            end
          end
          S_RECONF: begin
            wdog_cnt <= '0;
            if (rc_cnt == RC_LAST) state <= S_RUN;
            else                   rc_cnt <= rc_cnt + 1'b1;
          end
          S_RUN: begin
            if (frame_done) begin
              frame_cnt <= frame_cnt + 16'd1;
              wdog_cnt  <= '0;
              if (swap_pending) begin
                disp_buffer  <= ~disp_buffer;
                swap_pending <= 1'b0;
                swap_done    <= 1'b1;
              end
              if (commit_pending) begin
                act_n_rows     <= stg_n_rows;
                act_n_cols     <= stg_n_cols;
                act_bitdepth   <= stg_bitdepth;
                act_lsb_blank  <= stg_lsb_blank;
                commit_pending <= 1'b0;
                state          <= S_RECONF;
                rc_cnt         <= '0;
              end
            end else if (wdog_cnt == WD_LAST) begin
              wdog_err <= 1'b1;
              wdog_cnt <= '0;
              state    <= S_RECONF;
              rc_cnt   <= '0;
            end else begin
              wdog_cnt <= wdog_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end

      // New requests land after this edge's consumption, so same-cycle requests wait a frame.
      if (swap_req && !swap_pending) swap_pending <= 1'b1;
      if (commit_valid) commit_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_panel_frame_sched.sv
// Directed bench for panel_frame_sched: reset defaults, driver sequencing,
// swaps, config commits, same-cycle deferral, watchdog and enable drop.
module tb_panel_frame_sched;

  logic        clk = 1'b0;
  logic        ctrl_rst_n;
  logic        ctrl_en;
  logic [31:0] cfg_n_rows, cfg_n_cols, cfg_bitdepth, cfg_lsb_blank;
  logic        cfg_commit, swap_req, frame_done;
  logic [31:0] act_n_rows, act_n_cols, act_bitdepth, act_lsb_blank;
  logic        drv_en, drv_rst, disp_buffer, wr_buffer;
  logic        swap_pending, swap_done, cfg_err, wdog_err;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  panel_frame_sched #(
    .N_ROWS_MAX(64), .N_COLS_MAX(256), .BITDEPTH_MAX(8), .LSB_BLANK_MAX(200),
    .CTRL_WIDTH(32), .RECONF_CYCLES(2), .WDOG_CYCLES(100)
  ) dut (
    .clk(clk), .ctrl_rst_n(ctrl_rst_n), .ctrl_en(ctrl_en),
    .cfg_n_rows(cfg_n_rows), .cfg_n_cols(cfg_n_cols),
    .cfg_bitdepth(cfg_bitdepth), .cfg_lsb_blank(cfg_lsb_blank),
    .cfg_commit(cfg_commit), .swap_req(swap_req), .frame_done(frame_done),
    .act_n_rows(act_n_rows), .act_n_cols(act_n_cols),
    .act_bitdepth(act_bitdepth), .act_lsb_blank(act_lsb_blank),
    .drv_en(drv_en), .drv_rst(drv_rst), .disp_buffer(disp_buffer), .wr_buffer(wr_buffer),
    .swap_pending(swap_pending), .swap_done(swap_done),
    .cfg_err(cfg_err), .wdog_err(wdog_err), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input logic [31:0] r, input logic [31:0] c,
                         input logic [31:0] b, input logic [31:0] l);
    cfg_n_rows = r; cfg_n_cols = c; cfg_bitdepth = b; cfg_lsb_blank = l;
  endtask

  initial begin
    ctrl_rst_n = 1'b0; ctrl_en = 1'b0;
    cfg_commit = 1'b0; swap_req = 1'b0; frame_done = 1'b0;
    set_cfg(0, 0, 0, 0);
    cyc(3);

    // Reset defaults
    check("rst_drv_en", drv_en, 0);
    check("rst_drv_rst", drv_rst, 0);
    check("rst_disp", disp_buffer, 0);
    check("rst_wr", wr_buffer, 1);
    check("rst_rows", act_n_rows, 64);
    check("rst_cols", act_n_cols, 256);
    check("rst_depth", act_bitdepth, 8);
    check("rst_blank", act_lsb_blank, 0);
    check("rst_frames", frame_cnt, 0);
    check("rst_errs", {cfg_err, wdog_err, swap_pending, swap_done}, 0);

    // Release and enable: two RECONF cycles, then RUN
    ctrl_rst_n = 1'b1; ctrl_en = 1'b1;
    cyc(1);
    check("reconf1_rst", drv_rst, 1);
    check("reconf1_en", drv_en, 0);
    cyc(1);
    check("reconf2_rst", drv_rst, 1);
    cyc(1);
    check("run_en", drv_en, 1);
    check("run_rst", drv_rst, 0);
    check("run_disp", disp_buffer, 0);
    check("run_wr", wr_buffer, 1);

    // Swap request, frame_done ten cycles later
    swap_req = 1'b1; cyc(1); swap_req = 1'b0;
    check("swap_pend_set", swap_pending, 1);
    cyc(9);
    check("swap_pend_hold", swap_pending, 1);
    check("swap_no_early", disp_buffer, 0);
    frame_done = 1'b1; cyc(1); frame_done = 1'b0;
    check("swap_disp", disp_buffer, 1);
    check("swap_wr", wr_buffer, 0);
    check("swap_done_hi", swap_done, 1);
    check("swap_pend_clr", swap_pending, 0);
    check("swap_frames", frame_cnt, 1);
    cyc(1);
    check("swap_done_lo", swap_done, 0);

    // Valid commit applied at the next frame boundary
    set_cfg(5, 5, 4, 8);
    cfg_commit = 1'b1; cyc(1); cfg_commit = 1'b0;
    check("commit_not_yet", act_n_rows, 64);
    cyc(2);
    frame_done = 1'b1; cyc(1); frame_done = 1'b0;
    check("commit_rows", act_n_rows, 5);
    check("commit_cols", act_n_cols, 5);
    check("commit_depth", act_bitdepth, 4);
    check("commit_blank", act_lsb_blank, 8);
    check("commit_rst1", drv_rst, 1);
    check("commit_frames", frame_cnt, 2);
    cyc(1);
    check("commit_rst2", drv_rst, 1);
    cyc(1);
    check("commit_run", drv_en, 1);

    // Invalid commits: bitdepth over limit, cols over limit
    set_cfg(5, 5, 9, 8);
    cfg_commit = 1'b1; cyc(1); cfg_commit = 1'b0;
    check("bad_depth_err", cfg_err, 1);
    set_cfg(5, 257, 4, 8);
    cfg_commit = 1'b1; cyc(1); cfg_commit = 1'b0;
    frame_done = 1'b1; cyc(1); frame_done = 1'b0;
    check("bad_keep_depth", act_bitdepth, 4);
    check("bad_keep_cols", act_n_cols, 5);
    check("bad_no_reconf", drv_en, 1);
    check("bad_frames", frame_cnt, 3);

    // Swap and commit in the same cycle as frame_done are deferred
    cyc(2);
    set_cfg(7, 9, 6, 200);
    swap_req = 1'b1; cfg_commit = 1'b1; frame_done = 1'b1;
    cyc(1);
    swap_req = 1'b0; cfg_commit = 1'b0; frame_done = 1'b0;
    check("defer_disp", disp_buffer, 1);
    check("defer_rows", act_n_rows, 5);
    check("defer_done", swap_done, 0);
    check("defer_run", drv_en, 1);
    check("defer_pend", swap_pending, 1);
    check("defer_frames", frame_cnt, 4);
    cyc(3);
    frame_done = 1'b1; cyc(1); frame_done = 1'b0;
    check("both_disp", disp_buffer, 0);
    check("both_done", swap_done, 1);
    check("both_rows", act_n_rows, 7);
    check("both_cols", act_n_cols, 9);
    check("both_blank", act_lsb_blank, 200);
    check("both_reconf", drv_rst, 1);
    check("both_frames", frame_cnt, 5);
    cyc(2);
    check("both_run", drv_en, 1);

    // Watchdog: trips after 100 RUN cycles without frame_done
    cyc(99);
    check("wdog_quiet", wdog_err, 0);
    check("wdog_quiet_run", drv_en, 1);
    cyc(1);
    check("wdog_err", wdog_err, 1);
    check("wdog_reconf", drv_rst, 1);
    check("wdog_keep_rows", act_n_rows, 7);
    cyc(2);
    check("wdog_rerun", drv_en, 1);

    // Enable drop in RUN keeps a pending swap
    swap_req = 1'b1; cyc(1); swap_req = 1'b0;
    ctrl_en = 1'b0; cyc(1);
    check("idle_en", drv_en, 0);
    check("idle_rst", drv_rst, 0);
    check("idle_pend", swap_pending, 1);
    frame_done = 1'b1; cyc(1); frame_done = 1'b0;
    check("idle_no_swap", disp_buffer, 0);
    check("idle_no_count", frame_cnt, 5);

    // Reset discards pending work and sticky errors
    ctrl_rst_n = 1'b0; #2;
    check("rst2_pend", swap_pending, 0);
    check("rst2_errs", {cfg_err, wdog_err}, 0);
    check("rst2_rows", act_n_rows, 64);
    check("rst2_frames", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
